rr_encoder_arbiter: RTL

- N-way round-robin arbiter that shares one downstream resource between N requesters.
- Produces a one-hot grant and its binary-encoded index, the same N-to-clog2(N) encoding the encoder block provides.
- Holds a grant until the owner releases its request.
- Sits between requester agents and a shared datapath/bus; `gnt_idx` drives the datapath select.

---
 rtl/rr_encoder_arbiter_if.sv | 29 ++
 rtl/rr_encoder_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rr_encoder_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_encoder_arbiter_if                                                  |
// | Request/grant bundle between requester agents and the arbiter.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface rr_encoder_arbiter_if #(
  parameter int N = 8
) ();
  localparam int W = $clog2(N);

  logic         en;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic [W-1:0] gnt_idx;
  logic         gnt_valid;
  logic         timeout;

  modport master (
    output en, req,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  en, req,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface
`default_nettype wire

// File: rtl/rr_encoder_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_encoder_arbiter                                                     |
// | N-way round-robin arbiter, one-hot grant plus encoded index; optional |
// | hold-limit revocation enabled by defining ARB_TIMEOUT_EN.             |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_encoder_arbiter #(
  parameter int N        = 8,
  parameter int MAX_HOLD = 16
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  rr_encoder_arbiter_if.slave arb
);
  localparam int W = $clog2(N);

  if (N < 2 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_params
    $error("rr_encoder_arbiter: N must be >= 2 and MAX_HOLD in 1..255");
  end

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] gnt_q, gnt_d;
  logic         valid_q, valid_d;

  logic         release_grant;
  logic [W-1:0] search_ptr;
  logic [N-1:0] search_mask;
  logic [W:0]   pick;

`ifdef ARB_TIMEOUT_EN
  logic [7:0]   hold_q, hold_d;
  logic         timeout_q, timeout_d;
`endif

  // Returns {found, index} of the first set mask bit at or after start, wrapping.
  function automatic logic [W:0] pick_first(input logic [W-1:0] start,
                                            input logic [N-1:0] mask);
    logic [W:0] res;
    int         j;
    res = '0;
    for (int off = 0; off < N; off++) begin
      j = int'(start) + off;
      if (j >= N) j = j - N;
      if (!res[W] && mask[j]) res = {1'b1, W'(j)};
    end
    return res;
  endfunction

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    gnt_d         = gnt_q;
    valid_d       = valid_q;
    release_grant = 1'b0;
    search_ptr    = ptr_q;
    search_mask   = '0;
`ifdef ARB_TIMEOUT_EN
    hold_d        = hold_q;
    timeout_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        search_mask = arb.en ? arb.req : '0;
      end
      S_BUSY: begin
        if (~|(arb.req & gnt_q)) begin
          release_grant = 1'b1;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == 8'(MAX_HOLD - 1)) begin
          release_grant = 1'b1;
          timeout_d     = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
        if (release_grant) begin
          // Masking the owner also keeps a revoked owner out of this decision.
          ptr_d       = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
          search_ptr  = ptr_d;
          search_mask = arb.en ? (arb.req & ~gnt_q) : '0;
        end
      end
      default: ;
    endcase

    pick = pick_first(search_ptr, search_mask);

    if (pick[W]) begin
      state_d = S_BUSY;
      gnt_d   = N'(1) << pick[W-1:0];
      idx_d   = pick[W-1:0];
      valid_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
      hold_d  = 8'd0;
`endif
    end else if (release_grant) begin
      state_d = S_IDLE;
      gnt_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb.timeout = timeout_q;
`else
  assign arb.timeout = 1'b0;
`endif

  assign arb.gnt       = gnt_q;
  assign arb.gnt_idx   = idx_q;
  assign arb.gnt_valid = valid_q;

endmodule
`default_nettype wire
